// File: rtl/sh7034_dmac_arbiter.sv
// SH7034 DMAC channel arbiter: DMAOR.PR priority (fixed or round-robin), cycle-steal/burst hold.
// Optional per-channel grant counters are enabled with `define DMAC_ARB_STAT_EN.
module sh7034_dmac_arbiter #(
  parameter int unsigned NumCh     = 4,
  parameter int unsigned RrResetCh = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       ce_r_i,
  input  logic                       dme_i,
  input  logic                       halt_i,
  input  logic [1:0]                 pr_i,
  input  logic [NumCh-1:0]           ch_req_i,
  input  logic [NumCh-1:0]           ch_tm_i,
  input  logic                       bus_wait_i,
  input  logic                       cpu_lock_i,
  input  logic                       xfer_done_i,
  input  logic                       ch_end_i,
  output logic                       gnt_o,
  output logic [$clog2(NumCh)-1:0]   gnt_ch_o,
  output logic                       gnt_start_o,
`ifdef DMAC_ARB_STAT_EN
  input  logic                       stat_clr_i,
  output logic [16*NumCh-1:0]        gnt_cnt_o,
`endif
  output logic [$clog2(NumCh)-1:0]   rr_ptr_o
);

  localparam int unsigned ChW = $clog2(NumCh);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StActive  = 2'd1;
  localparam logic [1:0] StRelease = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             gnt_q, gnt_d;
  logic [ChW-1:0]   gnt_ch_q, gnt_ch_d;
  logic             gnt_start_q, gnt_start_d;
  logic [ChW-1:0]   rr_ptr_q, rr_ptr_d;

  logic [NumCh-1:0] elig;
  logic             any_elig;
  logic [ChW-1:0]   order [NumCh];
  logic [ChW-1:0]   winner;
  logic             burst_more;

  assign elig     = ch_req_i & {NumCh{dme_i & ~halt_i}};
  assign any_elig = |elig;

  // order[0] is the highest-priority channel for the current PR setting.
  always_comb begin
    for (int i = 0; i < NumCh; i++) begin
      order[i] = rr_ptr_q + ChW'(i);
    end
    case (pr_i)
      2'b00: begin
        order[0] = ChW'(0);
        order[1] = ChW'(3);
        order[2] = ChW'(2);
        order[3] = ChW'(1);
      end
      2'b01: begin
        order[0] = ChW'(0);
        order[1] = ChW'(2);
        order[2] = ChW'(3);
        order[3] = ChW'(1);
      end
      2'b10: begin
        order[0] = ChW'(2);
        order[1] = ChW'(0);
        order[2] = ChW'(1);
        order[3] = ChW'(3);
      end
      default: ;
    endcase
  end

  // Scan lowest priority first so the highest-priority eligible channel is the last write.
  always_comb begin
    winner = '0;
    for (int i = NumCh - 1; i >= 0; i--) begin
      if (elig[order[i]]) begin
        winner = order[i];
      end
    end
  end

  assign burst_more = ch_tm_i[gnt_ch_q] & ch_req_i[gnt_ch_q] & ~ch_end_i;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_ch_d    = gnt_ch_q;
    gnt_start_d = gnt_start_q;
    rr_ptr_d    = rr_ptr_q;
    if (ce_r_i) begin
      gnt_start_d = 1'b0;
      unique case (state_q)
        StIdle: begin
          if (any_elig && !bus_wait_i && !cpu_lock_i) begin
            gnt_ch_d    = winner;
            gnt_d       = 1'b1;
            gnt_start_d = 1'b1;
            state_d     = StActive;
          end
        end
        StActive: begin
          // HALT overrides a bus wait; everything else waits for the bus controller.
          if (halt_i) begin
            state_d = StRelease;
          end else if (!bus_wait_i) begin
            if (!dme_i) begin
              state_d = StRelease;
            end else if (xfer_done_i && !burst_more) begin
              state_d = StRelease;
            end
          end
        end
        StRelease: begin
          if (!bus_wait_i || halt_i) begin
            gnt_d   = 1'b0;
            state_d = StIdle;
            if (pr_i == 2'b11) begin
              rr_ptr_d = gnt_ch_q + ChW'(1);
            end
          end
        end
        default: begin
          gnt_d   = 1'b0;
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      gnt_q       <= 1'b0;
      gnt_ch_q    <= '0;
      gnt_start_q <= 1'b0;
      rr_ptr_q    <= ChW'(RrResetCh);
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_ch_q    <= gnt_ch_d;
      gnt_start_q <= gnt_start_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_ch_o    = gnt_ch_q;
  assign gnt_start_o = gnt_start_q;
  assign rr_ptr_o    = rr_ptr_q;

`ifdef DMAC_ARB_STAT_EN
  logic [15:0] cnt_q [NumCh];

  // Count once per grant: GNT_START stays high across CE_R-low cycles, so qualify with CE_R.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int c = 0; c < NumCh; c++) begin
        cnt_q[c] <= '0;
      end
    end else if (ce_r_i) begin
      for (int c = 0; c < NumCh; c++) begin
        if (stat_clr_i) begin
          cnt_q[c] <= '0;
        end else if (gnt_start_q && (gnt_ch_q == ChW'(c)) && (cnt_q[c] != 16'hFFFF)) begin
          cnt_q[c] <= cnt_q[c] + 16'd1;
        end
      end
    end
  end

  always_comb begin
    gnt_cnt_o = '0;
    for (int c = 0; c < NumCh; c++) begin
      gnt_cnt_o[16*c +: 16] = cnt_q[c];
    end
  end
`endif

endmodule
